// File: rtl/seven_seg_scan_decoder.sv
// Scrapes a multiplexed 7-segment bus back into per-slot BCD digits, with a
// stability filter, undecodable-pattern flags, frame completion and scan-error pulses.
module seven_seg_scan_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   an_in,
  output logic [4*NUM_DIGITS-1:0] digits_bcd,
  output logic [NUM_DIGITS-1:0]   digit_err,
  output logic                    frame_valid,
  output logic                    scan_err
);

  localparam int SW = NUM_DIGITS + 7;
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] LAST_COUNT = CW'(STABLE_CYCLES - 1);

  localparam logic [0:0] ST_SETTLE = 1'b0;
  localparam logic [0:0] ST_HOLD   = 1'b1;

  logic [SW-1:0]           r_sample;
  logic [SW-1:0]           r_prev;
  logic [SW-1:0]           r_acceptPat;
  logic                    r_pend;
  logic [0:0]              r_state;
  logic [CW-1:0]           r_count;
  logic [NUM_DIGITS-1:0]   r_seen;
  logic [4*NUM_DIGITS-1:0] r_digits;
  logic [NUM_DIGITS-1:0]   r_err;
  logic                    r_frame;
  logic                    r_scanErr;

  logic                    w_change;
  logic [CW-1:0]           w_countNext;
  logic [NUM_DIGITS-1:0]   w_acceptAn;
  logic [6:0]              w_acceptSeg;
  logic [3:0]              w_decBcd;
  logic                    w_decOk;
  logic                    w_multi;
  logic                    w_onehot;
  logic [NUM_DIGITS-1:0]   w_seenNext;

  assign w_change    = (r_sample != r_prev);
  assign w_countNext = r_count + 1'b1;

  // The accepted pattern is latched one edge before it is acted on, so a change
  // arriving right after the final stable sample cannot cancel an earned accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sample    <= '0;
      r_prev      <= '0;
      r_acceptPat <= '0;
      r_pend      <= 1'b0;
      r_state     <= ST_SETTLE;
      r_count     <= '0;
    end else begin
      r_sample <= {an_in, seg_in};
      r_prev   <= r_sample;
      r_pend   <= 1'b0;
      if (w_change) begin
        r_count <= '0;
        r_state <= ST_SETTLE;
      end else if (r_state == ST_SETTLE) begin
        r_count <= w_countNext;
        if (w_countNext == LAST_COUNT) begin
          r_state     <= ST_HOLD;
          r_pend      <= 1'b1;
          r_acceptPat <= r_sample;
        end
      end
    end
  end

  assign w_acceptAn  = ~r_acceptPat[SW-1:7];
  assign w_acceptSeg = r_acceptPat[6:0];

  always_comb begin
    w_decBcd = 4'hF;
    case (w_acceptSeg)
      7'b1111110: w_decBcd = 4'd0;
      7'b0110000: w_decBcd = 4'd1;
      7'b1101101: w_decBcd = 4'd2;
      7'b1111001: w_decBcd = 4'd3;
      7'b0110011: w_decBcd = 4'd4;
      7'b1011011: w_decBcd = 4'd5;
      7'b1011111: w_decBcd = 4'd6;
      7'b1110000: w_decBcd = 4'd7;
      7'b1111111: w_decBcd = 4'd8;
      7'b1111011: w_decBcd = 4'd9;
      default:    w_decBcd = 4'hF;
    endcase
  end

  assign w_decOk    = (w_decBcd != 4'hF);
  assign w_multi    = ((w_acceptAn & (w_acceptAn - 1'b1)) != '0);
  assign w_onehot   = (w_acceptAn != '0) && !w_multi;
  assign w_seenNext = r_seen | w_acceptAn;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_seen    <= '0;
      r_digits  <= '0;
      r_err     <= '0;
      r_frame   <= 1'b0;
      r_scanErr <= 1'b0;
    end else begin
      r_frame   <= 1'b0;
      r_scanErr <= 1'b0;
      if (r_pend) begin
        if (w_multi) begin
          r_scanErr <= 1'b1;
        end else if (w_onehot) begin
          for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_acceptAn[i]) begin
              r_digits[4*i +: 4] <= w_decBcd;
              r_err[i]           <= !w_decOk;
            end
          end
          if (&w_seenNext) begin
            r_frame <= 1'b1;
            r_seen  <= '0;
          end else begin
            r_seen <= w_seenNext;
          end
        end
      end
    end
  end

  assign digits_bcd  = r_digits;
  assign digit_err   = r_err;
  assign frame_valid = r_frame;
  assign scan_err    = r_scanErr;

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Directed-vector bench: the driver pushes hand-computed expectations (value and
// arrival edge) into a queue; an independent monitor pops one per output event.
module tb_seven_seg_scan_decoder;

  logic        clk;
  logic        rst_n;
  logic [6:0]  seg_in;
  logic [3:0]  an_in;
  logic [15:0] digits_bcd;
  logic [3:0]  digit_err;
  logic        frame_valid;
  logic        scan_err;

  typedef struct {
    int          cyc;
    logic [15:0] digits;
    logic [3:0]  derr;
    logic        fv;
    logic        se;
  } exp_t;

  exp_t        expQ[$];
  logic [15:0] mDigits;
  logic [3:0]  mErr;
  int          cyc;
  int          checks;
  int          errors;

  seven_seg_scan_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_in      (seg_in),
    .an_in       (an_in),
    .digits_bcd  (digits_bcd),
    .digit_err   (digit_err),
    .frame_valid (frame_valid),
    .scan_err    (scan_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] an, input logic [6:0] seg, input int n);
    an_in  = an;
    seg_in = seg;
    repeat (n) @(negedge clk);
  endtask

  // Outputs change 5 edges after the first sampling edge, which is cyc+1 here.
  task automatic showDigit(input int slot, input logic [6:0] seg, input logic [3:0] val,
                           input logic err, input logic fv);
    exp_t e;
    logic [3:0] an;
    mDigits[4*slot +: 4] = val;
    mErr[slot] = err;
    e.cyc = cyc + 6;
    e.digits = mDigits;
    e.derr = mErr;
    e.fv = fv;
    e.se = 1'b0;
    expQ.push_back(e);
    an = 4'b0001 << slot;
    an = ~an;
    applyStimulus(an, seg, 8);
    applyStimulus(4'hF, 7'h00, 2);
  endtask

  task automatic applyReset(input int n);
    rst_n = 1'b0;
    applyStimulus(4'hF, 7'h00, n);
    mDigits = '0;
    mErr = '0;
    rst_n = 1'b1;
    applyStimulus(4'hF, 7'h00, 2);
  endtask

  initial begin : monitor
    logic [15:0] prevDigits;
    logic [3:0]  prevErr;
    exp_t e;
    prevDigits = '0;
    prevErr = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        prevDigits = '0;
        prevErr = '0;
      end else if (digits_bcd !== prevDigits || digit_err !== prevErr ||
                   frame_valid !== 1'b0 || scan_err !== 1'b0) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_event: got digits=%h err=%b fv=%b se=%b, expected no event (cycle %0d)",
                   digits_bcd, digit_err, frame_valid, scan_err, cyc);
        end else begin
          e = expQ.pop_front();
          checkOutput("event_cycle", cyc, e.cyc);
          checkOutput("digits_bcd", {16'h0, digits_bcd}, {16'h0, e.digits});
          checkOutput("digit_err", {28'h0, digit_err}, {28'h0, e.derr});
          checkOutput("frame_valid", {31'h0, frame_valid}, {31'h0, e.fv});
          checkOutput("scan_err", {31'h0, scan_err}, {31'h0, e.se});
        end
        prevDigits = digits_bcd;
        prevErr = digit_err;
      end
    end
  end

  initial begin : stimulus
    exp_t e;
    checks = 0;
    errors = 0;
    mDigits = '0;
    mErr = '0;
    rst_n = 1'b0;
    an_in = 4'hF;
    seg_in = 7'h00;

    // Reset with random inputs: everything must read zero.
    for (int i = 0; i < 3; i++) begin
      an_in = 4'($urandom);
      seg_in = 7'($urandom);
      @(negedge clk);
      checkOutput("reset_digits", {16'h0, digits_bcd}, 32'h0);
      checkOutput("reset_err", {28'h0, digit_err}, 32'h0);
      checkOutput("reset_fv", {31'h0, frame_valid}, 32'h0);
      checkOutput("reset_se", {31'h0, scan_err}, 32'h0);
    end
    rst_n = 1'b1;
    applyStimulus(4'hF, 7'h00, 2);

    // Full scan 1,2,3,4 -> 4321 with frame pulse on slot 3.
    showDigit(0, 7'b0110000, 4'd1, 1'b0, 1'b0);
    showDigit(1, 7'b1101101, 4'd2, 1'b0, 1'b0);
    showDigit(2, 7'b1111001, 4'd3, 1'b0, 1'b0);
    showDigit(3, 7'b0110011, 4'd4, 1'b0, 1'b1);

    // Three-sample glitch is ignored; four samples are accepted.
    applyStimulus(4'b1110, 7'b1110000, 3);
    applyStimulus(4'hF, 7'h00, 6);
    mDigits[3:0] = 4'd7;
    e.cyc = cyc + 6;
    e.digits = mDigits;
    e.derr = mErr;
    e.fv = 1'b0;
    e.se = 1'b0;
    expQ.push_back(e);
    applyStimulus(4'b1110, 7'b1110000, 4);
    applyStimulus(4'hF, 7'h00, 6);

    // Undecodable pattern then recovery on slot 2.
    showDigit(2, 7'b0000001, 4'hF, 1'b1, 1'b0);
    showDigit(2, 7'b1111011, 4'd9, 1'b0, 1'b0);

    // Two anodes active at once.
    e.cyc = cyc + 6;
    e.digits = mDigits;
    e.derr = mErr;
    e.fv = 1'b0;
    e.se = 1'b1;
    expQ.push_back(e);
    applyStimulus(4'b1100, 7'b0110000, 8);
    applyStimulus(4'hF, 7'h00, 2);

    // Partial frame discarded by reset.
    showDigit(0, 7'b1011011, 4'd5, 1'b0, 1'b0);
    showDigit(1, 7'b1011111, 4'd6, 1'b0, 1'b0);
    applyReset(2);
    showDigit(2, 7'b1111111, 4'd8, 1'b0, 1'b0);
    showDigit(3, 7'b1101101, 4'd2, 1'b0, 1'b0);
    showDigit(0, 7'b1111001, 4'd3, 1'b0, 1'b0);
    showDigit(1, 7'b0110000, 4'd1, 1'b0, 1'b1);

    applyStimulus(4'hF, 7'h00, 12);
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      checks++;
      errors++;
      $display("[TB] FAIL missing_event: got nothing, expected digits=%h at cycle %0d", e.digits, e.cyc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
